// File: rtl/mem_stage_hs.sv
// MIPS MEM stage: variable-latency data-memory handshake with timeout, byte-lane steering,
// load extension and the MEM/WB register. Optional misaligned-access trap: MEM_MISALIGN_TRAP_EN.
module mem_stage_hs #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [1:0]        mem_size,
   input  logic              mem_unsigned,
   input  logic [ADDR_W-1:0] alu_result,
   input  logic [31:0]       B,
   input  logic [4:0]        dst_reg,
   input  logic              wb_reg_write,
   input  logic              wb_mem_to_reg,
   input  logic              pstop_i,
   output logic              stall_o,
   output logic [4:0]        MEM_WB_dst_reg,
   output logic              MEM_WB_reg_write,
   output logic              MEM_WB_mem_to_reg,
   output logic [31:0]       MEM_WB_mem_out,
   output logic [31:0]       MEM_WB_alu_out,
   output logic              MEM_WB_bus_err,
   output logic              d_read_en,
   output logic              d_write_en,
   output logic [3:0]        d_byte_en,
   output logic [ADDR_W-1:0] d_addr,
   output logic [31:0]       d_write_data,
   input  logic [31:0]       d_data_in,
   input  logic              d_ack,
   output logic [1:0]        dbg_state
);

   // Handshake: a request (d_read_en/d_write_en) is held with stable address/data until the
   // memory returns d_ack=1 for one cycle; the access completes in that cycle. A pending
   // request may be withdrawn only by pstop_i (resumes later), timeout abort, or reset.

   localparam int CNT_W = $clog2(TIMEOUT + 2);
   localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;

   logic        mem_op, access, misalign, req, timeout_hit;
   logic [1:0]  lane;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext, alu_ext;

   logic        wb_load;
   logic [4:0]  nxt_dst;
   logic        nxt_reg_write, nxt_mem_to_reg, nxt_bus_err;
   logic [31:0] nxt_mem_out, nxt_alu_out;

   assign mem_op = mem_read | mem_write;
   assign access = mem_op & ~pstop_i;
   assign lane   = alu_result[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign = access & (((mem_size == 2'b01) & lane[0]) | (mem_size[1] & (lane != 2'b00)));
`else
   assign misalign = 1'b0;
`endif

   assign req         = access & ~misalign;
   assign timeout_hit = (TIMEOUT != 0) && (state == S_WAIT) && (cnt == TO_VAL);
   assign stall_o     = req & ~d_ack & ~timeout_hit;

   // Requests drop in the very cycle reset is sampled.
   assign d_read_en  = req & mem_read & ~rst;
   assign d_write_en = req & mem_write & ~rst;
   assign d_addr     = {alu_result[ADDR_W-1:2], 2'b00};
   assign dbg_state  = state;

   generate
      if (ADDR_W >= 32) begin : g_alu_wide
         assign alu_ext = alu_result[31:0];
      end else begin : g_alu_narrow
         assign alu_ext = {{(32 - ADDR_W){1'b0}}, alu_result};
      end
   endgenerate

   always_comb begin
      d_byte_en    = 4'b1111;
      d_write_data = B;
      if (mem_write) begin
         case (mem_size)
            2'b00: begin
               d_byte_en    = 4'b0001 << lane;
               d_write_data = {4{B[7:0]}};
            end
            2'b01: begin
               d_byte_en    = lane[1] ? 4'b1100 : 4'b0011;
               d_write_data = {2{B[15:0]}};
            end
            default: begin
               d_byte_en    = 4'b1111;
               d_write_data = B;
            end
         endcase
      end
   end

   always_comb begin
      byte_sel = d_data_in[7:0];
      case (lane)
         2'd0: byte_sel = d_data_in[7:0];
         2'd1: byte_sel = d_data_in[15:8];
         2'd2: byte_sel = d_data_in[23:16];
         default: byte_sel = d_data_in[31:24];
      endcase
      half_sel = lane[1] ? d_data_in[31:16] : d_data_in[15:0];
      case (mem_size)
         2'b00:   load_ext = mem_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         2'b01:   load_ext = mem_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: load_ext = d_data_in;
      endcase
   end

   always_comb begin
      state_n        = state;
      cnt_n          = cnt;
      wb_load        = 1'b0;
      nxt_dst        = 5'd0;
      nxt_reg_write  = 1'b0;
      nxt_mem_to_reg = 1'b0;
      nxt_mem_out    = 32'd0;
      nxt_alu_out    = 32'd0;
      nxt_bus_err    = 1'b0;
      if (!pstop_i) begin
         wb_load = 1'b1;
         case (state)
            S_IDLE: begin
               if (req && !d_ack) begin
                  state_n = S_WAIT;
                  cnt_n   = CNT_W'(1);
               end
            end
            S_WAIT: begin
               if (!req || d_ack || timeout_hit) begin
                  state_n = S_IDLE;
                  cnt_n   = '0;
               end else if (cnt != CNT_MAX) begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
            default: begin
               state_n = S_IDLE;
               cnt_n   = '0;
            end
         endcase

         if (!mem_op) begin
            nxt_dst        = dst_reg;
            nxt_reg_write  = wb_reg_write;
            nxt_mem_to_reg = wb_mem_to_reg;
            nxt_alu_out    = alu_ext;
         end else if (misalign || (timeout_hit && !d_ack)) begin
            // Trap or abort: the instruction retires without a register write.
            nxt_dst     = dst_reg;
            nxt_alu_out = alu_ext;
            nxt_bus_err = 1'b1;
         end else if (d_ack) begin
            nxt_dst        = dst_reg;
            nxt_reg_write  = wb_reg_write;
            nxt_mem_to_reg = wb_mem_to_reg;
            nxt_mem_out    = mem_read ? load_ext : 32'd0;
            nxt_alu_out    = alu_ext;
         end
         // Otherwise still waiting: defaults form the bubble.
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= S_IDLE;
         cnt               <= '0;
         MEM_WB_dst_reg    <= 5'd0;
         MEM_WB_reg_write  <= 1'b0;
         MEM_WB_mem_to_reg <= 1'b0;
         MEM_WB_mem_out    <= 32'd0;
         MEM_WB_alu_out    <= 32'd0;
         MEM_WB_bus_err    <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (wb_load) begin
            MEM_WB_dst_reg    <= nxt_dst;
            MEM_WB_reg_write  <= nxt_reg_write;
            MEM_WB_mem_to_reg <= nxt_mem_to_reg;
            MEM_WB_mem_out    <= nxt_mem_out;
            MEM_WB_alu_out    <= nxt_alu_out;
            MEM_WB_bus_err    <= nxt_bus_err;
         end
      end
   end

endmodule
